// File: rtl/uart_tx_fifo_drain_if.sv
// Read-side link between the TX FIFO and the UART serialiser.
// fifo_rd_en is a one-cycle pop request, raised only after fifo_empty was seen low; fifo_dout is valid the following cycle.
interface uart_tx_fifo_drain_if #(
    parameter int DATA_BITS = 8
);
    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic [DATA_BITS-1:0] fifo_dout;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_dout
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_dout
    );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from the TX FIFO and sends each one as an 8N1 UART frame.
// All outputs are flops loaded from the next-state values, so they line up with the state register.
module uart_tx_fifo_drain #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int DATA_BITS    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tx_en,
    uart_tx_fifo_drain_if.master       fifo_bus,
    output logic                       serial_out,
    output logic                       tx_busy,
    output logic                       frame_done,
    output logic [2:0]                 dbg_state
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 bit_end;
    logic                 can_start;
    logic                 fifo_rd_en_q;

    assign bit_end   = (clk_cnt_q == CNT_LAST);
    assign can_start = tx_en && !fifo_bus.fifo_empty;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                if (can_start) state_d = FETCH;
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d   = fifo_bus.fifo_dout;
                clk_cnt_d = '0;
                state_d   = START;
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = can_start ? FETCH : IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            fifo_rd_en_q <= 1'b0;
            serial_out   <= 1'b1;
            tx_busy      <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            fifo_rd_en_q <= (state_d == FETCH);
            tx_busy      <= (state_d != IDLE);
            frame_done   <= (state_d == STOP) && (clk_cnt_d == CNT_LAST);
            // Line level follows the state being entered so it changes on the same edge.
            case (state_d)
                START:   serial_out <= 1'b0;
                DATA:    serial_out <= shift_d[0];
                default: serial_out <= 1'b1;
            endcase
        end
    end

    assign fifo_bus.fifo_rd_en = fifo_rd_en_q;
    assign dbg_state           = state_q;
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain with a behavioural 8-deep FIFO in front of it.
module tb_uart_tx_fifo_drain;
    localparam int C     = 4;
    localparam int FRAME = 10 * C;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       tx_en;
    logic       serial_out;
    logic       tx_busy;
    logic       frame_done;
    logic [2:0] dbg_state;

    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] mem [8];
    logic [3:0] cnt;
    logic [2:0] wp, rp;
    logic [7:0] dout_r;
    logic       fifo_full;
    logic       do_wr, do_rd;

    int checks;
    int errors;
    int rd_cnt;
    int done_cnt;
    int viol_cnt;
    logic [7:0] exp_q[$];
    int gap_q[$];

    int         mon_active;
    int         mon_cnt;
    logic [7:0] mon_byte;
    int         gap_track;
    int         gap_cnt;

    uart_tx_fifo_drain_if #(.DATA_BITS(8)) bus ();

    uart_tx_fifo_drain #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .fifo_bus  (bus.master),
        .serial_out(serial_out),
        .tx_busy   (tx_busy),
        .frame_done(frame_done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: registered dout, valid the cycle after rd_en
    assign fifo_full      = (cnt == 4'd8);
    assign bus.fifo_empty = (cnt == 4'd0);
    assign bus.fifo_dout  = dout_r;
    assign do_wr          = wr_en && !fifo_full;
    assign do_rd          = bus.fifo_rd_en && !bus.fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            wp     <= '0;
            rp     <= '0;
            dout_r <= '0;
        end else begin
            if (do_wr) begin
                mem[wp] <= wr_data;
                wp      <= wp + 3'd1;
            end
            if (do_rd) begin
                dout_r <= mem[rp];
                rp     <= rp + 3'd1;
            end
            cnt <= cnt + 4'(do_wr) - 4'(do_rd);
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.fifo_rd_en === 1'b1) rd_cnt++;
        if (bus.fifo_rd_en === 1'b1 && bus.fifo_empty) viol_cnt++;
        if (!rst && frame_done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // line decoder / scoreboard consumer
    initial begin
        int bi;
        mon_active = 0;
        mon_cnt    = 0;
        mon_byte   = '0;
        gap_track  = 0;
        gap_cnt    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 0;
                gap_track  = 0;
            end else if (mon_active == 0) begin
                if (serial_out === 1'b0) begin
                    mon_active = 1;
                    mon_cnt    = 0;
                    mon_byte   = '0;
                    if (gap_track != 0) gap_q.push_back(gap_cnt);
                    gap_track = 0;
                end else if (gap_track != 0) begin
                    gap_cnt++;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == C / 2) check("start_mid", 32'(serial_out), 32'd0);
                if (mon_cnt >= C + C / 2 && mon_cnt < 9 * C && ((mon_cnt - C / 2) % C) == 0) begin
                    bi = (mon_cnt - C - C / 2) / C;
                    mon_byte[bi[2:0]] = serial_out;
                end
                if (mon_cnt == 9 * C + C / 2) begin
                    check("stop_bit", 32'(serial_out), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", mon_byte);
                    end else begin
                        check("rx_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                    end
                end
                if (mon_cnt == FRAME - 1) begin
                    mon_active = 0;
                    gap_track  = 1;
                    gap_cnt    = 0;
                end
            end
        end
    end

    // driver tasks
    task automatic push(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(tx_busy == 1'b0 && bus.fifo_empty && mon_active == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle_timeout: waited %0d cycles, limit %0d", n, budget);
        end
    endtask

    initial begin
        vec_t vecs [4];
        int   rd0, done0, pushes;
        logic exp_ser;

        vecs[0] = '{data: 8'hA5, frame: 10'b1_1010_0101_0};
        vecs[1] = '{data: 8'h00, frame: 10'b1_0000_0000_0};
        vecs[2] = '{data: 8'hFF, frame: 10'b1_1111_1111_0};
        vecs[3] = '{data: 8'h5A, frame: 10'b1_0101_1010_0};

        checks   = 0;
        errors   = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        viol_cnt = 0;
        rst      = 1'b1;
        tx_en    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;

        // reset and idle
        repeat (2) @(negedge clk);
        check("rst_serial", 32'(serial_out), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_serial", 32'(serial_out), 32'd1);
            check("idle_busy", 32'(tx_busy), 32'd0);
        end
        check("idle_rd_cnt", 32'(rd_cnt), 32'd0);

        // single frames, cycle-exact against the table
        for (int v = 0; v < 4; v++) begin
            done0 = done_cnt;
            push(vecs[v].data);
            check("c0_rd_en", 32'(bus.fifo_rd_en), 32'd0);
            for (int n = 1; n <= 3 + FRAME; n++) begin
                @(negedge clk);
                if (n < 3 || n >= 3 + FRAME) exp_ser = 1'b1;
                else exp_ser = vecs[v].frame[(n - 3) / C];
                check("vec_rd_en", 32'(bus.fifo_rd_en), 32'(n == 1));
                check("vec_serial", 32'(serial_out), 32'(exp_ser));
                check("vec_done", 32'(frame_done), 32'(n == 3 + FRAME - 1));
                check("vec_busy", 32'(tx_busy), 32'(n < 3 + FRAME));
            end
            check("vec_done_cnt", 32'(done_cnt - done0), 32'd1);
            check("vec_empty", 32'(bus.fifo_empty), 32'd1);
            repeat (3) @(negedge clk);
        end

        // burst of three back-to-back pushes
        gap_q.delete();
        rd0 = rd_cnt;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h00; exp_q.push_back(8'h00);
        @(negedge clk);
        wr_data = 8'hFF; exp_q.push_back(8'hFF);
        @(negedge clk);
        wr_data = 8'h3C; exp_q.push_back(8'h3C);
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle(500);
        check("burst_rd_cnt", 32'(rd_cnt - rd0), 32'd3);
        check("burst_empty", 32'(bus.fifo_empty), 32'd1);
        check("burst_gap_n", 32'(gap_q.size()), 32'd3);
        if (gap_q.size() == 3) begin
            check("burst_gap1", 32'(gap_q[1]), 32'd2);
            check("burst_gap2", 32'(gap_q[2]), 32'd2);
        end

        // fill the FIFO with random bytes
        pushes = 0;
        @(negedge clk);
        while (!fifo_full && pushes < 16) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom_range(0, 255));
            exp_q.push_back(wr_data);
            pushes++;
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("fill_full", 32'(fifo_full), 32'd1);
        wait_idle(3000);
        check("fill_exp_empty", 32'(exp_q.size()), 32'd0);

        // tx_en gating
        tx_en = 1'b0;
        rd0 = rd_cnt;
        push(8'h55);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("gate_serial", 32'(serial_out), 32'd1);
        end
        check("gate_rd_cnt", 32'(rd_cnt - rd0), 32'd0);
        tx_en = 1'b1;
        @(negedge clk);
        check("gate_c1_rd_en", 32'(bus.fifo_rd_en), 32'd1);
        @(negedge clk);
        check("gate_c2_serial", 32'(serial_out), 32'd1);
        @(negedge clk);
        check("gate_c3_serial", 32'(serial_out), 32'd0);
        push(8'h99);
        repeat (3 * C - 2) @(negedge clk);
        tx_en = 1'b0;
        while (tx_busy == 1'b1 && rd_cnt - rd0 < 3 && mon_active >= 0) begin
            @(negedge clk);
            if (rd_cnt - rd0 > 1) break;
            if (tx_busy == 1'b0) break;
        end
        rd0 = rd_cnt;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("gate_hold_busy", 32'(tx_busy), 32'd0);
        end
        check("gate_hold_rd", 32'(rd_cnt - rd0), 32'd0);
        check("gate_fifo_cnt", 32'(cnt), 32'd1);
        check("gate_exp_left", 32'(exp_q.size()), 32'd1);
        tx_en = 1'b1;
        wait_idle(500);

        // reset in the middle of data bit 3
        push(8'h81);
        repeat (3 + 4 * C + 1) @(negedge clk);
        rd0 = rd_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_serial", 32'(serial_out), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        check("midrst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        @(negedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_rd_cnt", 32'(rd_cnt - rd0), 32'd0);
        check("midrst_busy_after", 32'(tx_busy), 32'd0);
        push(8'h7E);
        wait_idle(500);

        // final report
        check("no_pop_when_empty", 32'(viol_cnt), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1);
    end
endmodule
